// File: rtl/reply_frame_gen.sv
// reply_frame_gen: serializes one tag reply (pilot, preamble, payload, CRC-16,
// dummy 1) at one bit per BLF cycle toward the FM0/Miller encoder.
// Frame outputs are registered from the next state, so the first bit is on
// send_data in the cycle right after start is accepted.
module reply_frame_gen #(
  parameter int MAX_BITS = 128,
  parameter int LEN_W    = 8
) (
  input  logic                clk_blf,
  input  logic                rst_for_new_package,
  input  logic                start,
  input  logic [MAX_BITS-1:0] payload,
  input  logic [LEN_W-1:0]    payload_len,
  input  logic                crc_en,
  input  logic                trext,
  output logic                send_data,
  output logic                st_enc,
  output logic                fg_complete,
  output logic                busy
);

  // Counter must index both the payload and the 16 CRC bits.
  localparam int CNT_W = (LEN_W > 5) ? LEN_W : 5;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BITS);
  // Preamble 1,0,1,0,0,1 indexed by a counter running 5 down to 0.
  localparam logic [7:0] PREAMBLE_BITS = 8'b0010_1001;

  typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, PAYLOAD, CRC, DUMMY, DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [MAX_BITS-1:0] shreg, shreg_n;
  logic [LEN_W-1:0]    len_q, len_n;
  logic                crc_en_q, crc_en_n;
  logic                trext_q, trext_n;
  logic [15:0]         crc, crc_n;
  logic                send_n, st_n, fg_n;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign busy = (state != IDLE);

  // Next-state sequencing, CRC update and next registered output values.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    len_n     = len_q;
    crc_en_n  = crc_en_q;
    trext_n   = trext_q;
    crc_n     = crc;
    fg_n      = fg_complete;
    send_n    = 1'b0;
    st_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_n  = payload;
          len_n    = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
          crc_en_n = crc_en;
          trext_n  = trext;
          crc_n    = 16'hFFFF;
          fg_n     = 1'b0;
          if (trext) begin
            state_n   = PILOT;
            bit_cnt_n = CNT_W'(11);
          end else begin
            state_n   = PREAMBLE;
            bit_cnt_n = CNT_W'(5);
          end
        end
      end
      PILOT: begin
        if (bit_cnt == '0) begin
          state_n   = PREAMBLE;
          bit_cnt_n = CNT_W'(5);
        end else begin
          bit_cnt_n = bit_cnt - CNT_W'(1);
        end
      end
      PREAMBLE: begin
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - CNT_W'(1);
        end else if (len_q != '0) begin
          state_n   = PAYLOAD;
          bit_cnt_n = CNT_W'(len_q) - CNT_W'(1);
        end else if (crc_en_q) begin
          state_n   = CRC;
          bit_cnt_n = CNT_W'(15);
        end else begin
          state_n   = DUMMY;
          bit_cnt_n = '0;
        end
      end
      PAYLOAD: begin
        // The bit leaving now is shreg's MSB; fold it into the CRC.
        shreg_n = shreg << 1;
        crc_n   = crc16_step(crc, shreg[MAX_BITS-1]);
        if (bit_cnt != '0) begin
          bit_cnt_n = bit_cnt - CNT_W'(1);
        end else if (crc_en_q) begin
          state_n   = CRC;
          bit_cnt_n = CNT_W'(15);
        end else begin
          state_n   = DUMMY;
          bit_cnt_n = '0;
        end
      end
      CRC: begin
        if (bit_cnt == '0) begin
          state_n   = DUMMY;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt - CNT_W'(1);
        end
      end
      DUMMY:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      PILOT: st_n = 1'b1;
      PREAMBLE: begin
        st_n   = 1'b1;
        send_n = PREAMBLE_BITS[bit_cnt_n[2:0]];
      end
      PAYLOAD: begin
        st_n   = 1'b1;
        send_n = shreg_n[MAX_BITS-1];
      end
      CRC: begin
        st_n   = 1'b1;
        send_n = ~crc_n[bit_cnt_n[3:0]];
      end
      DUMMY: begin
        st_n   = 1'b1;
        send_n = 1'b1;
      end
      DONE:    fg_n = 1'b1;
      default: ;
    endcase
  end

  // Control state, CRC and registered encoder outputs.
  always_ff @(posedge clk_blf) begin
    if (rst_for_new_package) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      crc         <= 16'hFFFF;
      send_data   <= 1'b0;
      st_enc      <= 1'b0;
      fg_complete <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      crc         <= crc_n;
      send_data   <= send_n;
      st_enc      <= st_n;
      fg_complete <= fg_n;
    end
  end

  // Frame data latched at start and shifted during payload; no reset needed.
  always_ff @(posedge clk_blf) begin
    shreg    <= shreg_n;
    len_q    <= len_n;
    crc_en_q <= crc_en_n;
    trext_q  <= trext_n;
  end

endmodule

// File: tb/tb_reply_frame_gen.sv
// tb_reply_frame_gen: randomized scoreboard bench for reply_frame_gen.
module tb_reply_frame_gen;

  localparam int MAX_BITS = 128;
  localparam int LEN_W    = 8;

  logic                clk_blf = 1'b0;
  logic                rst_for_new_package;
  logic                start;
  logic [MAX_BITS-1:0] payload;
  logic [LEN_W-1:0]    payload_len;
  logic                crc_en;
  logic                trext;
  logic                send_data;
  logic                st_enc;
  logic                fg_complete;
  logic                busy;

  reply_frame_gen #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
    .clk_blf             (clk_blf),
    .rst_for_new_package (rst_for_new_package),
    .start               (start),
    .payload             (payload),
    .payload_len         (payload_len),
    .crc_en              (crc_en),
    .trext               (trext),
    .send_data           (send_data),
    .st_enc              (st_enc),
    .fg_complete         (fg_complete),
    .busy                (busy)
  );

  always #5 clk_blf = ~clk_blf;

  typedef struct {
    int total;
    bit crc;
    int pstart;
    int plen;
  } frame_t;

  bit     exp_bits[$];
  frame_t frames[$];
  bit     rx[$];
  int     run = 0;
  bit     post = 0;
  int     pass_cnt = 0;
  int     total_cnt = 0;
  int     timeout_cnt = 0;
  bit     tb_done = 0;
  logic   rst_seen = 1'b0;

  // Reference CRC: polynomial x^16+x^12+x^5+1 over a bit list, preset all ones.
  function automatic logic [15:0] ref_crc(input bit b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) c = (c << 1) ^ (((c[15] ^ b[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  // Reference model: the whole expected frame as a bit list.
  task automatic push_frame(input logic [MAX_BITS-1:0] pl, input int plen, input bit c, input bit t);
    int          n;
    bit          body[$];
    frame_t      f;
    logic [15:0] r;
    int          pre[6];
    pre = '{1, 0, 1, 0, 0, 1};
    n = (plen > MAX_BITS) ? MAX_BITS : plen;
    if (t) repeat (12) exp_bits.push_back(1'b0);
    foreach (pre[i]) exp_bits.push_back(pre[i] != 0);
    for (int i = 0; i < n; i++) begin
      body.push_back(pl[MAX_BITS-1-i]);
      exp_bits.push_back(pl[MAX_BITS-1-i]);
    end
    if (c) begin
      r = ~ref_crc(body);
      for (int i = 15; i >= 0; i--) exp_bits.push_back(r[i]);
    end
    exp_bits.push_back(1'b1);
    f.total  = (t ? 12 : 0) + 6 + n + (c ? 16 : 0) + 1;
    f.crc    = c;
    f.pstart = t ? 18 : 6;
    f.plen   = n;
    frames.push_back(f);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  always @(posedge clk_blf) rst_seen <= rst_for_new_package;

  // Monitor: pops expected bits/frames and checks whatever the DUT presents.
  always @(negedge clk_blf) begin
    if (tb_done) begin
      chk("leftover_bits", exp_bits.size(), 0);
      chk("leftover_frames", frames.size(), 0);
      chk("wait_timeouts", timeout_cnt, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
    end else if (rst_seen) begin
      chk("reset_outputs", {28'd0, send_data, st_enc, fg_complete, busy}, 0);
      exp_bits.delete();
      frames.delete();
      rx.delete();
      run  = 0;
      post = 0;
    end else begin
      if (post) begin
        chk("idle_after_done_fg_busy", {30'd0, fg_complete, busy}, 32'b10);
        post = 0;
      end
      if (st_enc) begin
        if (run == 0) chk("fg_clear_on_start", {31'd0, fg_complete}, 0);
        if (exp_bits.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_bit: st_enc high with no frame bit expected at %0t", $time);
        end else begin
          chk("frame_bit", {31'd0, send_data}, {31'd0, exp_bits.pop_front()});
        end
        rx.push_back(send_data);
        run++;
      end else if (run > 0) begin
        if (frames.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_frame: %0d bits with no frame expected", run);
        end else begin
          frame_t      f;
          logic [15:0] c;
          f = frames.pop_front();
          chk("frame_len", run, f.total);
          chk("done_cycle_fg_busy_data", {29'd0, fg_complete, busy, send_data}, 32'b110);
          if (f.crc) begin
            c = 16'hFFFF;
            for (int i = f.pstart; i < f.pstart + f.plen + 16 && i < rx.size(); i++)
              c = (c << 1) ^ (((c[15] ^ rx[i]) != 1'b0) ? 16'h1021 : 16'h0000);
            chk("crc_residue", {16'd0, c}, 32'h1D0F);
          end
        end
        post = 1;
        rx.delete();
        run = 0;
      end
    end
  end

  task automatic send_frame(input logic [MAX_BITS-1:0] pl, input int plen, input bit c, input bit t);
    payload     = pl;
    payload_len = plen[LEN_W-1:0];
    crc_en      = c;
    trext       = t;
    start       = 1'b1;
    @(posedge clk_blf);
    #1 start = 1'b0;
    push_frame(pl, plen, c, t);
  endtask

  // Returns on the falling edge of the first IDLE cycle after a frame.
  task automatic wait_frame();
    bit done;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk_blf);
      if (!busy) done = 1;
    end
    if (!done) timeout_cnt++;
  endtask

  function automatic logic [MAX_BITS-1:0] rand_pl();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lens[4];
    lens = '{1, 16, 96, 128};
    rst_for_new_package = 1'b1;
    start       = 1'b0;
    payload     = '0;
    payload_len = '0;
    crc_en      = 1'b0;
    trext       = 1'b0;
    repeat (3) @(posedge clk_blf);
    #1 rst_for_new_package = 1'b0;
    @(negedge clk_blf);

    // Short frame, then pilot frame with empty payload and CRC.
    send_frame(rand_pl(), 0, 1'b0, 1'b0);
    wait_frame();
    send_frame(rand_pl(), 0, 1'b1, 1'b1);
    wait_frame();

    // CRC residue over several payload lengths.
    foreach (lens[i]) begin
      send_frame(rand_pl(), lens[i], 1'b1, 1'($urandom_range(0, 1)));
      wait_frame();
    end

    // Length clamp.
    send_frame(rand_pl(), 200, 1'b0, 1'b0);
    wait_frame();

    // Start mid-frame is ignored; start in first IDLE cycle is accepted.
    send_frame(rand_pl(), 24, 1'b1, 1'b0);
    @(negedge clk_blf);
    @(negedge clk_blf);
    payload     = rand_pl();
    payload_len = 8'd5;
    trext       = 1'b1;
    start       = 1'b1;
    @(posedge clk_blf);
    #1 start = 1'b0;
    wait_frame();
    send_frame(rand_pl(), 10, 1'b0, 1'b1);
    wait_frame();

    // Reset during payload bit 5, then a full frame.
    send_frame(rand_pl(), 20, 1'b1, 1'b0);
    repeat (11) @(posedge clk_blf);
    #1 rst_for_new_package = 1'b1;
    @(posedge clk_blf);
    #1 rst_for_new_package = 1'b0;
    @(negedge clk_blf);
    @(negedge clk_blf);
    send_frame(rand_pl(), 40, 1'b1, 1'b0);
    wait_frame();

    // Random frames.
    repeat (5) begin
      send_frame(rand_pl(), $urandom_range(0, 140), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_frame();
    end

    repeat (3) @(negedge clk_blf);
    #1 tb_done = 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
